// File: rtl/merge_3.sv
// ============================================================================
// Module   : merge_3
// Purpose  : Writeback join for three execution branches; synchronised
//            4-phase req/ack on both sides, lowest-index arbitration.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module merge_3 #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_in_1,
    input  logic              req_in_2,
    input  logic              req_in_3,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic [4:0]        rd_1,
    input  logic [4:0]        rd_2,
    input  logic [4:0]        rd_3,
    input  logic              we_1,
    input  logic              we_2,
    input  logic              we_3,
    output logic              ack_out_1,
    output logic              ack_out_2,
    output logic              ack_out_3,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    output logic [4:0]        rd_out,
    output logic              we_out,
    input  logic              ack_in,
    output logic              err_multi
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_RTZ  = 2'd2;

    logic [3:0] w_async;
    logic [3:0] w_sync;
    logic [2:0] w_req_s;
    logic       w_ack_s;

    assign w_async = {ack_in, req_in_3, req_in_2, req_in_1};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sync = w_async;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][3:0] r_sync;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= w_async;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_req_s = w_sync[2:0];
    assign w_ack_s = w_sync[3];

    logic [2:0]        w_gnt;
    logic              w_multi;
    logic [DATA_W-1:0] w_data_g;
    logic [4:0]        w_rd_g;
    logic              w_we_g;

    assign w_multi = (w_req_s[0] & w_req_s[1]) | (w_req_s[0] & w_req_s[2]) |
                     (w_req_s[1] & w_req_s[2]);

    // Fixed priority: branch 1 beats 2 beats 3.
    always_comb begin
        w_gnt    = 3'b000;
        w_data_g = data_3;
        w_rd_g   = rd_3;
        w_we_g   = we_3;
        if (w_req_s[0]) begin
            w_gnt    = 3'b001;
            w_data_g = data_1;
            w_rd_g   = rd_1;
            w_we_g   = we_1;
        end else if (w_req_s[1]) begin
            w_gnt    = 3'b010;
            w_data_g = data_2;
            w_rd_g   = rd_2;
            w_we_g   = we_2;
        end else if (w_req_s[2]) begin
            w_gnt    = 3'b100;
        end
    end

    logic [1:0]        r_state;
    logic [2:0]        r_gnt;
    logic [2:0]        r_ack;
    logic              r_req_out;
    logic [DATA_W-1:0] r_data;
    logic [4:0]        r_rd;
    logic              r_we;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_gnt     <= 3'b000;
            r_ack     <= 3'b000;
            r_req_out <= 1'b0;
            r_data    <= '0;
            r_rd      <= 5'd0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|w_req_s) begin
                        r_gnt     <= w_gnt;
                        r_data    <= w_data_g;
                        r_rd      <= w_rd_g;
                        r_we      <= w_we_g;
                        r_req_out <= 1'b1;
                        r_state   <= c_SEND;
                        if (w_multi) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_SEND: begin
                    if (w_ack_s) begin
                        r_req_out <= 1'b0;
                        r_ack     <= r_gnt;
                        r_state   <= c_RTZ;
                    end
                end
                c_RTZ: begin
                    // Wait for the granted branch to withdraw its request so it is not re-served.
                    if (((w_req_s & r_gnt) == 3'b000) && !w_ack_s) begin
                        r_ack   <= 3'b000;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ack_out_1 = r_ack[0];
    assign ack_out_2 = r_ack[1];
    assign ack_out_3 = r_ack[2];
    assign req_out   = r_req_out;
    assign data_out  = r_data;
    assign rd_out    = r_rd;
    assign we_out    = r_we;
    assign err_multi = r_err;

endmodule

`default_nettype wire

// File: tb/tb_merge_3.sv
// ============================================================================
// Module   : tb_merge_3
// Purpose  : Directed self-checking bench for merge_3 (SYNC_STAGES 2 and 0).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_merge_3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_in_1 = 0, req_in_2 = 0, req_in_3 = 0;
    logic [31:0] data_1 = 0, data_2 = 0, data_3 = 0;
    logic [4:0]  rd_1 = 0, rd_2 = 0, rd_3 = 0;
    logic        we_1 = 0, we_2 = 0, we_3 = 0;
    logic        ack_in = 0;
    logic        ack_out_1, ack_out_2, ack_out_3, req_out, we_out, err_multi;
    logic [31:0] data_out;
    logic [4:0]  rd_out;

    logic        b_req_1 = 0, b_ack_in = 0;
    logic        b_ack_out_1, b_ack_out_2, b_ack_out_3, b_req_out, b_we_out, b_err;
    logic [31:0] b_data_out;
    logic [4:0]  b_rd_out;

    int n_checks = 0;
    int n_errors = 0;

    logic inv_bad = 1'b0;
    logic watch13 = 1'b0;
    logic bad13 = 1'b0;

    always #5 clk = ~clk;

    merge_3 #(.DATA_W(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_in_1(req_in_1), .req_in_2(req_in_2), .req_in_3(req_in_3),
        .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .rd_1(rd_1), .rd_2(rd_2), .rd_3(rd_3),
        .we_1(we_1), .we_2(we_2), .we_3(we_3),
        .ack_out_1(ack_out_1), .ack_out_2(ack_out_2), .ack_out_3(ack_out_3),
        .req_out(req_out), .data_out(data_out), .rd_out(rd_out), .we_out(we_out),
        .ack_in(ack_in), .err_multi(err_multi)
    );

    merge_3 #(.DATA_W(32), .SYNC_STAGES(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n),
        .req_in_1(b_req_1), .req_in_2(1'b0), .req_in_3(1'b0),
        .data_1(32'hCAFE0001), .data_2(32'h0), .data_3(32'h0),
        .rd_1(5'd9), .rd_2(5'd0), .rd_3(5'd0),
        .we_1(1'b1), .we_2(1'b0), .we_3(1'b0),
        .ack_out_1(b_ack_out_1), .ack_out_2(b_ack_out_2), .ack_out_3(b_ack_out_3),
        .req_out(b_req_out), .data_out(b_data_out), .rd_out(b_rd_out), .we_out(b_we_out),
        .ack_in(b_ack_in), .err_multi(b_err)
    );

    // Output-exclusivity watchers, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && ((int'(ack_out_1) + int'(ack_out_2) + int'(ack_out_3) > 1) ||
                      (req_out && (ack_out_1 || ack_out_2 || ack_out_3))))
            inv_bad <= 1'b1;
        if (watch13 && (ack_out_1 || ack_out_3))
            bad13 <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic ack_of(input int g);
        case (g)
            1: return ack_out_1;
            2: return ack_out_2;
            default: return ack_out_3;
        endcase
    endfunction

    // Completes a writeback handshake for branch g from the SEND state.
    task automatic handshake(input int g, input string tag);
        ack_in = 1'b1;
        tick(2);
        check({tag, "_ack_early"}, ack_of(g), 1'b0);
        tick(1);
        check({tag, "_ack_rise"}, ack_of(g), 1'b1);
        check({tag, "_req_drop"}, req_out, 1'b0);
        case (g)
            1: req_in_1 = 1'b0;
            2: req_in_2 = 1'b0;
            default: req_in_3 = 1'b0;
        endcase
        ack_in = 1'b0;
        tick(3);
        check({tag, "_ack_fall"}, ack_of(g), 1'b0);
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_req_out", req_out, 1'b0);
        check("rst_acks", {ack_out_1, ack_out_2, ack_out_3}, 3'b000);
        check("rst_out", {data_out, rd_out, we_out, err_multi}, '0);
        rst_n = 1'b1;
        tick(1);

        // Single ALU request
        req_in_3 = 1'b1; data_3 = 32'hDEADBEEF; rd_3 = 5'd5; we_3 = 1'b1;
        tick(2);
        check("alu_req_early", req_out, 1'b0);
        tick(1);
        check("alu_req_out", req_out, 1'b1);
        check("alu_data", data_out, 32'hDEADBEEF);
        check("alu_rd", rd_out, 5'd5);
        check("alu_we", we_out, 1'b1);
        handshake(3, "alu");
        check("alu_err", err_multi, 1'b0);

        // Store with no writeback
        watch13 = 1'b1;
        req_in_2 = 1'b1; data_2 = 32'h12345678; rd_2 = 5'd0; we_2 = 1'b0;
        tick(3);
        check("st_req_out", req_out, 1'b1);
        check("st_we", we_out, 1'b0);
        check("st_data", data_out, 32'h12345678);
        handshake(2, "st");
        watch13 = 1'b0;
        check("st_other_acks", bad13, 1'b0);

        // Simultaneous 1 and 3, plus data change during SEND
        data_1 = 32'h11111111; rd_1 = 5'd1; we_1 = 1'b1;
        data_3 = 32'h33333333; rd_3 = 5'd7; we_3 = 1'b1;
        req_in_1 = 1'b1; req_in_3 = 1'b1;
        tick(3);
        check("mul_req_out", req_out, 1'b1);
        check("mul_data1", data_out, 32'h11111111);
        check("mul_err", err_multi, 1'b1);
        data_1 = 32'hAAAAAAAA; rd_1 = 5'd2;
        tick(1);
        check("hold_data", data_out, 32'h11111111);
        check("hold_rd", rd_out, 5'd1);
        handshake(1, "mul1");
        check("mul_ack3_low", ack_out_3, 1'b0);
        tick(1);
        check("mul3_req_out", req_out, 1'b1);
        check("mul3_data", data_out, 32'h33333333);
        check("mul3_rd", rd_out, 5'd7);
        handshake(3, "mul3");
        check("mul_err_sticky", err_multi, 1'b1);

        // Reset while in RTZ
        req_in_2 = 1'b1; data_2 = 32'h0BADF00D; rd_2 = 5'd3; we_2 = 1'b1;
        tick(3);
        check("rz_req_out", req_out, 1'b1);
        ack_in = 1'b1;
        tick(3);
        check("rz_ack2", ack_out_2, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rz_ack2_clr", ack_out_2, 1'b0);
        check("rz_req_clr", req_out, 1'b0);
        check("rz_err_clr", err_multi, 1'b0);
        req_in_2 = 1'b0; ack_in = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        req_in_1 = 1'b1;
        tick(2);
        check("post_rst_early", req_out, 1'b0);
        tick(1);
        check("post_rst_req", req_out, 1'b1);
        check("post_rst_data", data_out, 32'hAAAAAAAA);
        handshake(1, "post_rst");
        check("post_rst_err", err_multi, 1'b0);

        // Zero-stage synchroniser build
        b_req_1 = 1'b1;
        tick(1);
        check("s0_req_out", b_req_out, 1'b1);
        check("s0_data", b_data_out, 32'hCAFE0001);
        b_ack_in = 1'b1;
        tick(1);
        check("s0_ack_rise", b_ack_out_1, 1'b1);
        check("s0_req_drop", b_req_out, 1'b0);
        b_req_1 = 1'b0; b_ack_in = 1'b0;
        tick(1);
        check("s0_ack_fall", {b_ack_out_1, b_ack_out_2, b_ack_out_3, b_err}, 4'b0000);

        check("exclusive_outputs", inv_bad, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/merge_3.md
Name: merge_3

Overview:
- Writeback-side join for the three execution branches: branch/jump unit (1), load/store unit (2), ALU/NOP unit (3).
- Each branch presents a result under a 4-phase return-to-zero req/ack handshake.
- merge_3 synchronises the handshake inputs into the clock domain, captures one result, and forwards it to the register-file writeback port under its own 4-phase handshake.
- Exactly one branch is active per instruction by construction. Simultaneous requests are still arbitrated and flagged.

Parameters:
- DATA_W, 32, width of result data.
- SYNC_STAGES, 2, flip-flop synchroniser depth on req_in_1..3 and ack_in. Legal values 0..3; 0 means inputs are used directly.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in_1, req_in_2, req_in_3  input  1 each  branch result request.
- data_1, data_2, data_3  input  DATA_W each  branch result, stable while the matching req_in is high.
- rd_1, rd_2, rd_3  input  5 each  destination register.
- we_1, we_2, we_3  input  1 each  register write enable. Branch/store without link drives 0.
- ack_out_1, ack_out_2, ack_out_3  output  1 each  acknowledge to branch.
- req_out  output  1  writeback request.
- data_out  output  DATA_W  captured result.
- rd_out  output  5  captured destination.
- we_out  output  1  captured write enable.
- ack_in  input  1  writeback acknowledge.
- err_multi  output  1  sticky flag: more than one synchronised req_in high in IDLE.

Behaviour:
- Reset: rst_n low asynchronously clears all of the following, regardless of state:
  - all synchroniser flops, FSM state (IDLE), grant register;
  - req_out, ack_out_1..3, data_out, rd_out, we_out, err_multi.
  - After release, first state evaluation is at the next rising edge. Reset mid-transaction abandons the transaction; no output glitches high.
- Synchronisers: req_s_i and ack_s are req_in_i and ack_in delayed by SYNC_STAGES flops.
- FSM states: IDLE, SEND, RTZ. All outputs are registered.
- IDLE:
  - If any req_s_i = 1, grant the lowest index: 1 beats 2 beats 3.
  - Capture data_g, rd_g, we_g into the output registers and set req_out = 1. Next state SEND.
  - If two or more req_s_i = 1 on that edge, set err_multi = 1. It stays set until reset.
- SEND:
  - Hold req_out and the captured outputs.
  - When ack_s = 1: req_out <= 0, ack_out_g <= 1. Next state RTZ.
  - Changes on req_in or data inputs while in SEND are ignored; data was already captured.
- RTZ:
  - Hold ack_out_g = 1.
  - When req_s_g = 0 and ack_s = 0 on the same edge: ack_out_g <= 0. Next state IDLE.
  - Ungranted requests stay pending and are served from IDLE afterwards, ungranted ack_out stays 0.
- Latency (req_in_g first sampled high at edge 1):
  - req_out rises at edge SYNC_STAGES+1.
  - ack_out_g rises SYNC_STAGES+1 edges after ack_in is first sampled high.
  - ack_out_g falls SYNC_STAGES+1 edges after the later of req_in_g low / ack_in low.
  - With SYNC_STAGES=2, minimum full cycle is 9 edges.
- Output rules:
  - data_out/rd_out/we_out change only on the IDLE->SEND edge; otherwise they hold their last value.
  - At most one ack_out_i is high at any time. req_out and any ack_out_i are never high on the same cycle.
- Back-to-back: a new req_in_g rising during RTZ is not taken until the FSM returns to IDLE. Since req_s_g must be seen low first, no request is lost or double-counted.

Test Plan:
- Reset then single ALU request (SYNC_STAGES=2):
  - req_in_3=1, data_3=0xDEADBEEF, rd_3=5, we_3=1 at edge 1 -> req_out=1 at edge 3 with data_out=0xDEADBEEF, rd_out=5, we_out=1.
  - ack_in=1 -> ack_out_3=1 three edges later, req_out=0.
  - Drop req_in_3 and ack_in -> ack_out_3=0 three edges later; err_multi=0.
- Store with no writeback:
  - req_in_2, we_2=0, rd_2=0 -> we_out=0 presented with req_out.
  - Handshake completes; ack_out_1 and ack_out_3 stay 0 throughout.
- Simultaneous req_in_1 and req_in_3 on the same edge:
  - Branch 1 granted first, err_multi=1.
  - After branch 1 completes RTZ, branch 3 is served with its own data; err_multi stays 1.
- Data change after capture: change data_1 while in SEND -> data_out keeps the value captured on IDLE->SEND.
- Reset mid-transaction: assert rst_n=0 while in RTZ with ack_out_2=1 -> ack_out_2, req_out and err_multi go 0 immediately without a clock; state IDLE after release.
- SYNC_STAGES=0 build: req_in_1 sampled at edge 1 -> req_out=1 at edge 1; the full 4-phase cycle completes in 3 edges.
